// File: rtl/rr_mux_sched_16x8.sv
// Round-robin scheduler driving a shared 8:1 W-bit mux into one registered output stage,
// with optional burst locking that keeps one requester on the mux for up to BURST beats.
module rr_mux_sched_16x8 #(
  parameter int W     = 16,
  parameter int BURST = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [7:0]     in_valid,
  input  logic [8*W-1:0] in_data,
  output logic [7:0]     in_ready,
  output logic           out_valid,
  output logic [W-1:0]   out_data,
  output logic [2:0]     out_src,
  input  logic           out_ready
);

  localparam logic [4:0] BURST_V = 5'(BURST);
  localparam logic       MULTI   = (BURST > 1);

  logic [2:0]   ptr_q, ptr_d;
  logic         locked_q, locked_d;
  logic [2:0]   owner_q, owner_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [2:0]   sel_q, sel_d;
  logic         out_valid_q, out_valid_d;
  logic [W-1:0] out_data_q, out_data_d;
  logic [2:0]   out_src_q, out_src_d;

  logic         load;
  logic         own_vld;
  logic         found;
  logic         xfer;
  logic         last_beat;
  logic [2:0]   start;
  logic [2:0]   idx;
  logic [2:0]   pick;
  logic [2:0]   sel;
  logic [W-1:0] sel_word;

  // Arbitration: a held lock wins, otherwise first valid channel from the start index.
  always_comb begin
    load    = !out_valid_q || out_ready;
    own_vld = in_valid[owner_q];
    start   = locked_q ? owner_q + 3'd1 : ptr_q;
    found   = 1'b0;
    pick    = sel_q;
    idx     = '0;
    for (int i = 0; i < 8; i++) begin
      idx = start + 3'(i);
      if (!found && in_valid[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
    sel  = (locked_q && own_vld) ? owner_q : pick;
    xfer = load && in_valid[sel];
  end

  always_comb begin
    in_ready = '0;
    if (xfer && rst_n) in_ready[sel] = 1'b1;
  end

  always_comb begin
    sel_word = '0;
    for (int k = 0; k < 8; k++) begin
      if (sel == 3'(k)) sel_word = in_data[k*W +: W];
    end
  end

  // Output register: reloads whenever it is empty or being drained.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    if (load) begin
      out_valid_d = xfer;
      if (xfer) begin
        out_data_d = sel_word;
        out_src_d  = sel;
      end
    end
  end

  // Lock / pointer control; everything freezes while the output stalls.
  always_comb begin
    ptr_d     = ptr_q;
    locked_d  = locked_q;
    owner_d   = owner_q;
    cnt_d     = cnt_q;
    sel_d     = sel;
    last_beat = (({1'b0, cnt_q} + 5'd1) == BURST_V);
    if (load) begin
      if (locked_q && own_vld) begin
        if (last_beat) begin
          locked_d = 1'b0;
          ptr_d    = owner_q + 3'd1;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end else begin
        if (locked_q) begin
          locked_d = 1'b0;
          ptr_d    = owner_q + 3'd1;
          cnt_d    = '0;
        end
        if (xfer) begin
          if (MULTI) begin
            locked_d = 1'b1;
            owner_d  = sel;
            cnt_d    = 4'd1;
          end else begin
            ptr_d = sel + 3'd1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q       <= '0;
      locked_q    <= 1'b0;
      owner_q     <= '0;
      cnt_q       <= '0;
      sel_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
    end else begin
      ptr_q       <= ptr_d;
      locked_q    <= locked_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      sel_q       <= sel_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;

endmodule

// File: tb/tb_rr_mux_sched_16x8.sv
// Bench for rr_mux_sched_16x8: a BURST=4 and a BURST=1 instance checked every cycle
// against a behavioural model, plus directed sequences with literal expectations.
module tb_rr_mux_sched_16x8;
  localparam int W = 16;

  typedef struct {
    int ptr;
    bit locked;
    int owner;
    int cnt;
    bit ov;
    int od;
    int os;
  } mst_t;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [7:0]     iv [2];
  logic [7:0]     ir [2];
  logic [8*W-1:0] id [2];
  logic           ordy [2];
  logic           ov [2];
  logic [W-1:0]   od [2];
  logic [2:0]     os [2];

  int   sq [2][8];
  int   bb [2];
  int   bp [2] = '{4, 1};
  mst_t m [2];
  int   checks = 0;
  int   errors = 0;
  int   srcq4[$];
  int   datq4[$];
  int   srcq1[$];

  always #5 clk = ~clk;

  rr_mux_sched_16x8 #(.W(W), .BURST(4)) u4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_data(id[0]), .in_ready(ir[0]),
    .out_valid(ov[0]), .out_data(od[0]), .out_src(os[0]), .out_ready(ordy[0]));

  rr_mux_sched_16x8 #(.W(W), .BURST(1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_data(id[1]), .in_ready(ir[1]),
    .out_valid(ov[1]), .out_data(od[1]), .out_src(os[1]), .out_ready(ordy[1]));

  // Channel k word = {k, sequence byte}; the sequence advances each time the word is taken.
  always_comb begin
    for (int i = 0; i < 2; i++)
      for (int k = 0; k < 8; k++)
        id[i][k*W +: W] = {8'(k), 8'(sq[i][k] + bb[i])};
  end

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++)
      for (int k = 0; k < 8; k++)
        if (rst_n && ir[i][k]) sq[i][k] <= sq[i][k] + 1;
  end

  function automatic int mgrant(mst_t s, logic [7:0] v, logic rdy);
    int st;
    if (s.ov && !rdy) return -1;
    if (s.locked && v[s.owner]) return s.owner;
    st = s.locked ? (s.owner + 1) % 8 : s.ptr;
    for (int j = 0; j < 8; j++)
      if (v[(st + j) % 8]) return (st + j) % 8;
    return -1;
  endfunction

  function automatic mst_t mstep(mst_t s, logic [7:0] v, logic [8*W-1:0] d, logic rdy, int b);
    mst_t n;
    int g;
    n = s;
    if (s.ov && !rdy) return s;
    g = mgrant(s, v, rdy);
    n.ov = (g >= 0);
    if (g >= 0) begin
      n.od = int'(d[g*W +: W]);
      n.os = g;
    end
    if (s.locked) begin
      if (v[s.owner]) begin
        if (s.cnt + 1 == b) begin
          n.locked = 0;
          n.ptr    = (s.owner + 1) % 8;
          n.cnt    = 0;
        end else begin
          n.cnt = s.cnt + 1;
        end
        return n;
      end
      n.locked = 0;
      n.ptr    = (s.owner + 1) % 8;
      n.cnt    = 0;
    end
    if (g >= 0) begin
      if (b > 1) begin
        n.locked = 1;
        n.owner  = g;
        n.cnt    = 1;
      end else begin
        n.ptr = (g + 1) % 8;
      end
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) m[i] <= '{default: 0};
      else        m[i] <= mstep(m[i], iv[i], id[i], ordy[i], bp[i]);
    end
  end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      int g;
      logic [7:0] ev;
      g  = mgrant(m[i], iv[i], ordy[i]);
      ev = (rst_n && g >= 0) ? 8'(1 << g) : 8'h00;
      chk($sformatf("in_ready[u%0d]", i), 32'(ir[i]), 32'(ev));
      chk($sformatf("out_valid[u%0d]", i), 32'(ov[i]), 32'(m[i].ov));
      if (m[i].ov) begin
        chk($sformatf("out_data[u%0d]", i), 32'(od[i]), 32'(m[i].od));
        chk($sformatf("out_src[u%0d]", i), 32'(os[i]), 32'(m[i].os));
      end
    end
    if (rst_n && ov[0] && ordy[0]) begin
      srcq4.push_back(int'(os[0]));
      datq4.push_back(int'(od[0]));
    end
    if (rst_n && ov[1] && ordy[1]) srcq1.push_back(int'(os[1]));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    srcq4.delete();
    datq4.delete();
    srcq1.delete();
  endtask

  task automatic chk_seq(string nm, int q[$], int req[]);
    chk({nm, "_len"}, 32'(q.size() >= req.size() ? req.size() : q.size()), 32'(req.size()));
    for (int j = 0; j < req.size(); j++)
      if (j < q.size()) chk($sformatf("%s[%0d]", nm, j), 32'(q[j]), 32'(req[j]));
  endtask

  initial begin
    int rr[];
    int bs[];
    int er[];
    rst_n   = 1'b0;
    iv[0]   = 8'hff;
    iv[1]   = 8'hff;
    ordy[0] = 1'b1;
    ordy[1] = 1'b1;
    bb[0]   = 0;
    bb[1]   = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(ov[0]), 32'h0);
    chk("rst_out_data", 32'(od[0]), 32'h0);
    chk("rst_out_src", 32'(os[0]), 32'h0);
    chk("rst_in_ready_u4", 32'(ir[0]), 32'h0);
    chk("rst_in_ready_u1", 32'(ir[1]), 32'h0);
    iv[0] = 8'h00;
    iv[1] = 8'h00;
    rst_n = 1'b1;
    tick();

    // Single channel 3 streaming with BURST=4.
    srcq4.delete();
    datq4.delete();
    iv[0] = 8'h08;
    repeat (6) tick();
    chk("single_len", 32'(srcq4.size()), 32'd5);
    if (srcq4.size() >= 5) begin
      chk("single_first_data", 32'(datq4[0]), 32'h0300);
      for (int j = 0; j < 5; j++) chk($sformatf("single_src[%0d]", j), 32'(srcq4[j]), 32'd3);
      for (int j = 0; j < 4; j++)
        chk($sformatf("single_seq[%0d]", j), 32'(datq4[j+1]), 32'(datq4[0] + j + 1));
    end
    iv[0] = 8'h00;
    tick();

    // Burst lock on u4 (ch0, ch5) alongside full round robin on u1.
    do_reset();
    iv[0] = 8'h21;
    iv[1] = 8'hff;
    repeat (11) tick();
    rr = '{0, 1, 2, 3, 4, 5, 6, 7, 0, 1};
    bs = '{0, 0, 0, 0, 5, 5, 5, 5, 0, 0};
    chk_seq("rr_src", srcq1, rr);
    chk_seq("burst_src", srcq4, bs);
    iv[0] = 8'h00;
    iv[1] = 8'h00;
    tick();

    // Backpressure: one word 0x00A1 held for three stalled cycles.
    do_reset();
    bb[0]   = 8'hA1 - sq[0][0];
    iv[0]   = 8'h01;
    ordy[0] = 1'b0;
    tick();
    for (int j = 0; j < 3; j++) begin
      chk($sformatf("bp_data[%0d]", j), 32'(od[0]), 32'h00A1);
      chk($sformatf("bp_valid[%0d]", j), 32'(ov[0]), 32'h1);
      chk($sformatf("bp_ready[%0d]", j), 32'(ir[0]), 32'h00);
      tick();
    end
    chk("bp_data_hold", 32'(od[0]), 32'h00A1);
    ordy[0] = 1'b1;
    #1;
    chk("bp_reload_ready", 32'(ir[0]), 32'h01);
    tick();
    chk("bp_next_data", 32'(od[0]), 32'h00A2);
    iv[0] = 8'h00;
    tick();

    // Early release: ch1 leaves after two beats, ch2 takes over with no bubble.
    do_reset();
    iv[0] = 8'h06;
    tick();
    tick();
    iv[0] = 8'h04;
    #1;
    chk("early_ready", 32'(ir[0]), 32'h04);
    repeat (5) tick();
    er = '{1, 1, 2, 2, 2, 2};
    chk_seq("early_src", srcq4, er);
    iv[0] = 8'h00;
    tick();

    // Reset in the middle of a ch6 burst.
    do_reset();
    iv[0] = 8'h40;
    tick();
    tick();
    chk("mid_pre_valid", 32'(ov[0]), 32'h1);
    #1;
    rst_n = 1'b0;
    iv[0] = 8'h42;
    #1;
    chk("mid_rst_valid", 32'(ov[0]), 32'h0);
    chk("mid_rst_data", 32'(od[0]), 32'h0);
    chk("mid_rst_ready", 32'(ir[0]), 32'h00);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("mid_first_grant", 32'(ir[0]), 32'h02);
    tick();
    chk("mid_first_src", 32'(os[0]), 32'd1);
    chk("mid_first_valid", 32'(ov[0]), 32'h1);
    iv[0] = 8'h00;
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
